// File: rtl/rr_decode_arbiter4.sv
// rr_decode_arbiter4: round-robin arbiter for four requesters with a bounded hold time and a registered, decoded one-hot grant
module rr_decode_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       switch
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, last_q, last_d, win;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic switch_q, switch_d, found, own_req, at_limit, take;
  logic [3:0] cand;
  always_comb begin
    cand = (state_q == GRANT) ? req & ~(4'b0001 << idx_q) : req;
    win = last_q;
    found = 1'b0;
    // Scan from the farthest offset down so the nearest requester after last wins.
    for (int k = 4; k >= 1; k--)
      if (cand[last_q + 2'(k)]) begin
        win = last_q + 2'(k);
        found = 1'b1;
      end
    own_req = req[idx_q];
    at_limit = hold_q == LIMIT;
    take = found && (state_q == IDLE || !own_req || at_limit);
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    hold_d = hold_q;
    switch_d = 1'b0;
    if (take) begin
      state_d = GRANT;
      idx_d = win;
      last_d = win;
      hold_d = '0;
      switch_d = 1'b1;
    end else if (state_q == GRANT && !own_req)
      state_d = IDLE;
    else if (state_q == GRANT && !at_limit)
      hold_d = hold_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 2'b00;
      last_q <= 2'b11;
      hold_q <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      hold_q <= hold_d;
      switch_q <= switch_d;
    end
  end
  assign gnt_valid = state_q == GRANT;
  assign gnt = gnt_valid ? 4'b0001 << idx_q : 4'b0000;
  assign gnt_idx = idx_q;
  assign switch = switch_q;
endmodule

// File: tb/tb_rr_decode_arbiter4.sv
// tb_rr_decode_arbiter4: directed checks of the round-robin arbiter at MAX_HOLD=8 and MAX_HOLD=4
module tb_rr_decode_arbiter4;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, gnt4;
  logic [1:0] gnt_idx, gnt_idx4;
  logic gnt_valid, gnt_valid4, switch, switch4;
  int checks = 0, failures = 0;
  rr_decode_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .switch(switch));
  rr_decode_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .gnt_idx(gnt_idx4),
    .gnt_valid(gnt_valid4), .switch(switch4));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
    checks++; if (gnt_idx !== 2'b00) begin failures++; $display("FAIL reset_idx got=%b exp=00", gnt_idx); end
    checks++; if (switch !== 1'b0) begin failures++; $display("FAIL reset_switch got=%b exp=0", switch); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL post_reset_gnt got=%b exp=0001", gnt); end
    checks++; if (switch !== 1'b1) begin failures++; $display("FAIL post_reset_switch got=%b exp=1", switch); end
  endtask
  task automatic test_idle_grant();
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin failures++; $display("FAIL release_to_idle got=%b/%b exp=0000/0", gnt, gnt_valid); end
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL idle_grant_gnt got=%b exp=0100", gnt); end
    checks++; if (gnt_idx !== 2'b10) begin failures++; $display("FAIL idle_grant_idx got=%b exp=10", gnt_idx); end
    checks++; if (switch !== 1'b1) begin failures++; $display("FAIL idle_grant_switch got=%b exp=1", switch); end
    tick();
    checks++; if (switch !== 1'b0 || gnt !== 4'b0100) begin failures++; $display("FAIL hold_switch got=%b/%b exp=0/0100", switch, gnt); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin failures++; $display("FAIL drop_gnt got=%b/%b exp=0000/0", gnt, gnt_valid); end
    checks++; if (gnt_idx !== 2'b10) begin failures++; $display("FAIL drop_idx_kept got=%b exp=10", gnt_idx); end
  endtask
  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_g = 4'b0001 << ((c / 4) % 4);
      checks++; if (gnt4 !== exp_g) begin failures++; $display("FAIL rot_gnt c=%0d got=%b exp=%b", c, gnt4, exp_g); end
      checks++; if (switch4 !== (c % 4 == 0)) begin failures++; $display("FAIL rot_switch c=%0d got=%b exp=%b", c, switch4, c % 4 == 0); end
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL b2b_owner got=%b exp=0010", gnt); end
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010 || switch !== 1'b0) begin failures++; $display("FAIL b2b_undisturbed got=%b/%b exp=0010/0", gnt, switch); end
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000 || gnt_valid !== 1'b1) begin failures++; $display("FAIL b2b_handoff got=%b/%b exp=1000/1", gnt, gnt_valid); end
    checks++; if (switch !== 1'b1) begin failures++; $display("FAIL b2b_switch got=%b exp=1", switch); end
    checks++; if (gnt4 !== 4'b1000) begin failures++; $display("FAIL b2b_handoff4 got=%b exp=1000", gnt4); end
  endtask
  task automatic test_lone_owner();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lone_gnt c=%0d got=%b exp=0001", c, gnt); end
      checks++; if (switch !== (c == 0)) begin failures++; $display("FAIL lone_switch c=%0d got=%b exp=%b", c, switch, c == 0); end
    end
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0010 || switch !== 1'b1) begin failures++; $display("FAIL saturated_preempt got=%b/%b exp=0010/1", gnt, switch); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 19; c++) tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_hold_owner got=%b exp=0100", gnt); end
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || switch !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%b/%b exp=0000/0/0", gnt, gnt_valid, switch); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001 || switch !== 1'b1) begin failures++; $display("FAIL after_mid_reset got=%b/%b exp=0001/1", gnt, switch); end
  endtask
  initial begin
    test_reset();
    test_idle_grant();
    test_rotation();
    test_back_to_back();
    test_lone_owner();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
